// File: rtl/rc4_pkg.sv
// Shared types and sizes for the RC4 key-scheduling datapath.
// The S-memory is a 256x8 single-port array with registered read data.
package rc4_pkg;
  localparam int S_SIZE    = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int KEY_BYTES = 3;

  typedef logic [ADDR_W-1:0] s_addr_t;
  typedef logic [DATA_W-1:0] s_data_t;

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    WAIT_I,
    LATCH_I,
    READ_J,
    WAIT_J,
    LATCH_J,
    WRITE_I,
    WRITE_J,
    DONE
  } ksa_state_t;
endpackage

// File: rtl/ksa_shuffler.sv
// RC4 KSA swap pass: for i=0..255, j += S[i] + key[i mod KEY_BYTES], swap S[i], S[j].
// Drives the single-port S-memory directly; each iteration takes eight cycles.
//   state   | meaning
//   IDLE    | wait for start, latch key, clear i/j/kidx
//   READ_I  | present address i
//   WAIT_I  | hold address i while memory reads
//   LATCH_I | capture S[i], update j
//   READ_J  | present updated j
//   WAIT_J  | hold address j while memory reads
//   LATCH_J | capture S[j]
//   WRITE_I | S[i] <= old S[j]
//   WRITE_J | S[j] <= old S[i], advance i or finish
//   DONE    | finished held until start drops
module ksa_shuffler
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES,
  parameter int ADDR_W    = rc4_pkg::ADDR_W,
  parameter int DATA_W    = rc4_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [DATA_W-1:0]      q,
  output logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      data,
  output logic                   write_enable,
  output logic                   finished
);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  ksa_state_t               state_q, state_d;
  logic [ADDR_W-1:0]        i_q, i_d, j_q, j_d;
  logic [KIDX_W-1:0]        kidx_q, kidx_d;
  logic [DATA_W-1:0]        si_q, si_d, sj_q, sj_d;
  logic [8*KEY_BYTES-1:0]   key_q, key_d;

  // Byte 0 sits in the most significant byte of the key vector.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] k,
                                          input logic [KIDX_W-1:0]      idx);
    key_byte = k[8*(KEY_BYTES-1-int'(idx)) +: 8];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    kidx_d       = kidx_q;
    si_d         = si_q;
    sj_d         = sj_q;
    key_d        = key_q;
    address      = '0;
    data         = '0;
    write_enable = 1'b0;
    finished     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = READ_I;
        end
      end
      READ_I: begin
        address = i_q;
        state_d = WAIT_I;
      end
      WAIT_I: begin
        address = i_q;
        state_d = LATCH_I;
      end
      LATCH_I: begin
        address = i_q;
        si_d    = q;
        j_d     = j_q + ADDR_W'(q) + ADDR_W'(key_byte(key_q, kidx_q));
        state_d = READ_J;
      end
      READ_J: begin
        address = j_q;
        state_d = WAIT_J;
      end
      WAIT_J: begin
        address = j_q;
        state_d = LATCH_J;
      end
      LATCH_J: begin
        address = j_q;
        sj_d    = q;
        state_d = WRITE_I;
      end
      WRITE_I: begin
        address      = i_q;
        data         = sj_q;
        write_enable = 1'b1;
        state_d      = WRITE_J;
      end
      WRITE_J: begin
        address      = j_q;
        data         = si_q;
        write_enable = 1'b1;
        if (i_q == '1) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          kidx_d  = (kidx_q == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
          state_d = READ_I;
        end
      end
      DONE: begin
        finished = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ksa_shuffler.sv
// Self-checking bench for ksa_shuffler: behavioural memory, software KSA golden model.
module tb_ksa_shuffler;
  localparam int N = rc4_pkg::S_SIZE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        write_enable;
  logic        finished;

  ksa_shuffler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .q(q), .address(address), .data(data), .write_enable(write_enable),
    .finished(finished)
  );

  always #5 clk = ~clk;

  // S-memory model: registered read, write-first ignored (old data on collision)
  logic [7:0] mem [N];
  logic       init_req = 1'b0;
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < N; k++) mem[k] <= 8'(k);
    end else if (write_enable) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

  int n_chk = 0;
  int n_pass = 0;

  int         gold [N];
  logic [7:0] exp_a [2*N];
  logic [7:0] exp_d [2*N];
  logic [7:0] wlog_a [6];
  logic [7:0] wlog_d [6];
  logic [7:0] snap [N];

  typedef struct {
    logic [23:0] key;
    bit          fresh;
    int          drop_at;
    bit          chk_w;
    logic [7:0]  w0a, w0d, w1a, w1d;
  } vec_t;

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Software KSA over gold[], recording the write sequence the swaps imply.
  task automatic ksa_model(input logic [23:0] key);
    int j, t, kb;
    j = 0;
    for (int i = 0; i < N; i++) begin
      kb = int'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
      j = (j + gold[i] + kb) % 256;
      exp_a[2*i]   = 8'(i);
      exp_d[2*i]   = 8'(gold[j]);
      exp_a[2*i+1] = 8'(j);
      exp_d[2*i+1] = 8'(gold[i]);
      t = gold[i]; gold[i] = gold[j]; gold[j] = t;
    end
  endtask

  task automatic init_mem();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
    for (int k = 0; k < N; k++) gold[k] = k;
  endtask

  task automatic run_pass(input logic [23:0] key, input int drop_at);
    int n, widx, wrun, bad;
    bit done, seen [N];
    ksa_model(key);
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    n = 0; widx = 0; wrun = 0; done = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 10) secret_key = 24'($urandom);
      if (drop_at != 0 && n == drop_at) start = 1'b0;
      if (write_enable) begin
        if (widx < 2*N) begin
          chk(address == exp_a[widx], "write_addr", int'(address), int'(exp_a[widx]));
          chk(data == exp_d[widx], "write_data", int'(data), int'(exp_d[widx]));
          if (widx < 6) begin wlog_a[widx] = address; wlog_d[widx] = data; end
        end else begin
          chk(1'b0, "extra_write", widx, 2*N);
        end
        widx++; wrun++;
      end else begin
        if (wrun != 0) chk(wrun == 2, "write_pair_len", wrun, 2);
        wrun = 0;
      end
      if (finished) done = 1'b1;
    end
    chk(n == 2049, "latency", n, 2049);
    chk(widx == 2*N, "write_count", widx, 2*N);
    chk(write_enable == 1'b0, "done_we", int'(write_enable), 0);
    if (drop_at == 0) begin
      repeat (3) @(negedge clk);
      chk(finished == 1'b1, "finished_hold", int'(finished), 1);
      start = 1'b0;
    end
    @(negedge clk);
    chk(finished == 1'b0, "finished_drop", int'(finished), 0);
    bad = 0;
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (int'(mem[k]) != gold[k]) bad++;
      seen[mem[k]] = 1'b1;
    end
    chk(bad == 0, "mem_vs_golden", bad, 0);
    bad = 0;
    for (int k = 0; k < N; k++) if (!seen[k]) bad++;
    chk(bad == 0, "permutation_missing", bad, 0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{key: 24'h000000, fresh: 1, drop_at: 0,    chk_w: 1, w0a: 8'h00, w0d: 8'h00, w1a: 8'h00, w1d: 8'h00};
    vecs[1] = '{key: 24'h010203, fresh: 1, drop_at: 0,    chk_w: 1, w0a: 8'h00, w0d: 8'h01, w1a: 8'h01, w1d: 8'h00};
    vecs[2] = '{key: 24'hFFFFFF, fresh: 1, drop_at: 0,    chk_w: 1, w0a: 8'h00, w0d: 8'hFF, w1a: 8'hFF, w1d: 8'h00};
    vecs[3] = '{key: 24'h010203, fresh: 1, drop_at: 1700, chk_w: 1, w0a: 8'h00, w0d: 8'h01, w1a: 8'h01, w1d: 8'h00};
    vecs[4] = '{key: 24'h010203, fresh: 0, drop_at: 0,    chk_w: 0, w0a: 8'h00, w0d: 8'h00, w1a: 8'h00, w1d: 8'h00};

    // Reset values
    repeat (2) @(negedge clk);
    chk(address == 8'h00, "reset_address", int'(address), 0);
    chk(data == 8'h00, "reset_data", int'(data), 0);
    chk(write_enable == 1'b0, "reset_we", int'(write_enable), 0);
    chk(finished == 1'b0, "reset_finished", int'(finished), 0);
    reset_n = 1'b1;
    init_mem();

    // Reset mid-run at cycle 500
    @(negedge clk);
    secret_key = 24'h123456;
    start = 1'b1;
    repeat (500) @(negedge clk);
    reset_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk(write_enable == 1'b0, "midreset_we", int'(write_enable), 0);
    chk(finished == 1'b0, "midreset_finished", int'(finished), 0);
    chk(address == 8'h00, "midreset_address", int'(address), 0);
    for (int k = 0; k < N; k++) snap[k] = mem[k];
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    begin
      int moved;
      moved = 0;
      for (int k = 0; k < N; k++) if (mem[k] != snap[k]) moved++;
      chk(moved == 0, "idle_mem_static", moved, 0);
    end
    chk(address == 8'h00, "idle_address", int'(address), 0);
    chk(finished == 1'b0, "idle_finished", int'(finished), 0);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].fresh) init_mem();
      run_pass(vecs[v].key, vecs[v].drop_at);
      if (vecs[v].chk_w) begin
        chk(wlog_a[0] == vecs[v].w0a, "first_write_addr", int'(wlog_a[0]), int'(vecs[v].w0a));
        chk(wlog_d[0] == vecs[v].w0d, "first_write_data", int'(wlog_d[0]), int'(vecs[v].w0d));
        chk(wlog_a[1] == vecs[v].w1a, "second_write_addr", int'(wlog_a[1]), int'(vecs[v].w1a));
        chk(wlog_d[1] == vecs[v].w1d, "second_write_data", int'(wlog_d[1]), int'(vecs[v].w1d));
      end
      if (vecs[v].key == 24'h000000 && vecs[v].fresh) begin
        chk(wlog_a[2] == 8'h01 && wlog_a[3] == 8'h01, "i1_same_addr", int'(wlog_a[3]), 1);
        chk(wlog_d[2] == wlog_d[3], "i1_same_data", int'(wlog_d[3]), int'(wlog_d[2]));
        chk(wlog_a[4] == 8'h02 && wlog_d[4] == 8'h03, "i2_write_i", int'({wlog_a[4], wlog_d[4]}), 16'h0203);
        chk(wlog_a[5] == 8'h03 && wlog_d[5] == 8'h02, "i2_write_j", int'({wlog_a[5], wlog_d[5]}), 16'h0302);
      end
    end

    // Random keys, including a chained second pass
    for (int r = 0; r < 4; r++) begin
      if (r != 3) init_mem();
      run_pass(24'($urandom), (r == 1) ? int'($urandom_range(1, 2000)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ksa_shuffler.md
Name: ksa_shuffler

Overview:
- Second stage of the RC4 key-scheduling algorithm (KSA).
- Runs after ram_initializer has written S[i]=i into the 256x8 S-memory; starts from ram_initializer's finished signal.
- For i=0..255: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- Drives the single-port S-memory directly; asserts finished for the downstream PRGA/decrypt stage.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes.
- ADDR_W, 8, S-memory address width (256 entries).
- DATA_W, 8, S-memory data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level request; tied to ram_initializer finished.
- secret_key  input  8*KEY_BYTES  key; byte 0 is secret_key[8*KEY_BYTES-1 -: 8] (MSB first).
- q  input  DATA_W  S-memory read data; valid one cycle after the address is presented.
- address  output  ADDR_W  S-memory address.
- data  output  DATA_W  S-memory write data.
- write_enable  output  1  S-memory write strobe.
- finished  output  1  shuffle complete.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; i=0, j=0, kidx=0, si=0, sj=0, key_q=0. Outputs: address=0, data=0, write_enable=0, finished=0.
- IDLE: when start=1, latch secret_key into key_q, clear i, j and kidx, go to READ_I. The key is sampled only at this point.
- Each iteration takes exactly 8 states, one cycle each:
  1. READ_I: address=i.
  2. WAIT_I: address=i.
  3. LATCH_I: si<=q; j<=j+q+key_q[kidx] (mod 256, wraps naturally).
  4. READ_J: address=j (the updated j).
  5. WAIT_J: address=j.
  6. LATCH_J: sj<=q.
  7. WRITE_I: address=i, data=sj, write_enable=1.
  8. WRITE_J: address=j, data=si, write_enable=1. Then:
     - if i==255, go to DONE;
     - else i<=i+1, kidx<=(kidx==KEY_BYTES-1)?0:kidx+1, go to READ_I.
- write_enable is high only in WRITE_I and WRITE_J.
- Total latency from the IDLE cycle that sees start=1 to finished=1: 1+256*8 = 2049 cycles.
- i==j: both writes target the same location with the same value; the memory is unchanged, and no special case is needed.
- kidx is a wrap counter; no modulo operator is used.
- DONE: finished=1 and write_enable=0. finished holds while start=1. When start=0, go to IDLE and drop finished on the next cycle. A new start=1 reruns the shuffle on the current memory contents.
- start is ignored in every state except IDLE and DONE. Deasserting start mid-shuffle does not abort.
- reset_n low mid-operation: immediate return to IDLE, outputs at reset values. A partially shuffled memory is not restored.

Decomposition:
- rc4_pkg holds:
  - typedef enum ksa_state_t {IDLE, READ_I, WAIT_I, LATCH_I, READ_J, WAIT_J, LATCH_J, WRITE_I, WRITE_J, DONE};
  - localparams S_SIZE=256, ADDR_W, DATA_W, KEY_BYTES;
  - typedef s_addr_t, s_data_t.
- No sub-module needed. Key-byte selection is a small function inside the module (or in the package).

Test Plan:
- Reset/idle: reset_n=0 mid-run at cycle 500 -> next cycle write_enable=0, finished=0, address=0; with start=0, nothing moves.
- Key 0x000000 on a memory model preloaded with S[i]=i, start=1 -> iteration i=2 writes S[2]=3 then S[3]=2; i=0 and i=1 write identical values (i==j); finished rises exactly 2049 cycles after start.
- Key 0x010203 -> iteration i=0 computes j=1; writes address 0 data 1, then address 1 data 0. The final memory equals a software KSA golden model for key 010203, byte for byte, and is a permutation of 0..255.
- Start toggling: start=0 after 1700 cycles (mid-run) -> no abort, finished at cycle 2049. Then start=0 -> finished=0 one cycle later. start=1 again -> a second full pass whose result matches the golden model for two KSA passes.
- Protocol check on every cycle: the two write strobes are on consecutive cycles, each READ address is held for 2 cycles, and there is no write outside WRITE_I/WRITE_J.
- Key 0xFFFFFF -> j wraps modulo 256 (i=0: j=0xFF) and the final memory matches the golden model.
